mac_mem_bank: RTL and testbench
===============================

Name: mac_mem_bank

Overview:
- Parametrised operand/result storage for the MAC-stop matrix engine. Holds matrix A (MxK), matrix B (KxN) and result matrix C (MxN).
- Independent read and write ports per matrix. Reads are registered with 1-cycle latency and a valid strobe.
- C supports accumulate-writes (C += data) and a sequential hardware clear engine with busy/done handshake.
- Sits between the load/store controller and the MAC array. It replaces the combinational-read, single-address matrix store.

Parameters:
- M, 4: rows of A and C; >= 2.
- K, 4: columns of A / rows of B; >= 2.
- N, 4: columns of B and C; >= 2.
- DW_IN, 32: element width of A and B.
- DW_OUT, 2*DW_IN+$clog2(K): element width of C.

Ports:
- clk  in  1  clock; all logic on rising edge.
- resetn  in  1  synchronous, active-low reset.
- a_we  in  1  write A[a_wrow][a_wcol] <= a_wdata.
- a_wrow / a_wcol  in  $clog2(M) / $clog2(K)  A write address.
- a_wdata  in  DW_IN  A write data.
- a_re  in  1  read request for A.
- a_rrow / a_rcol  in  $clog2(M) / $clog2(K)  A read address.
- a_rdata  out  DW_IN  registered A read data.
- a_rvalid  out  1  a_rdata valid.
- b_we, b_wrow, b_wcol, b_wdata, b_re, b_rrow, b_rcol, b_rdata, b_rvalid: same as A. Row widths use $clog2(K), column widths $clog2(N).
- c_we  in  1  C write enable.
- c_acc  in  1  with c_we: accumulate instead of overwrite.
- c_wrow / c_wcol  in  $clog2(M) / $clog2(N)  C write address.
- c_wdata  in  DW_OUT  C write/addend data.
- c_re, c_rrow, c_rcol, c_rdata (DW_OUT), c_rvalid: C read port, same timing as A.
- clr_start  in  1  pulse: start clearing all of C.
- clr_busy  out  1  clear engine active.
- clr_done  out  1  one-cycle pulse when the clear completes.
- c_wr_drop  out  1  one-cycle pulse: a C write was dropped because the clear engine was busy.

Behaviour:
- Reset (resetn=0 at posedge):
  - All A, B and C entries become 0.
  - All rdata = 0, all rvalid = 0.
  - clr_busy = 0, clr_done = 0, c_wr_drop = 0, clear counter = 0.
  - Reset during a clear aborts the clear; clr_done is not pulsed.
- Writes: take effect at the posedge where the corresponding we=1.
- Read latency:
  - A re=1 sampled at edge t gives rdata = array[addr] and rvalid=1 after edge t.
  - If re=0 at edge t, rdata=0 and rvalid=0 after edge t.
- Read-during-write, same entry and same edge: read returns the OLD value (read-first). The new value is visible to a read issued on the next cycle.
- Out-of-range addresses (index >= M/K/N, only possible with non-power-of-2 dims):
  - The write is ignored.
  - The read returns rdata=0 with rvalid=1.
- C accumulate (c_we=1, c_acc=1): C[r][c] <= C[r][c] + c_wdata, modulo 2^DW_OUT. No saturation.
- C overwrite: c_we=1 with c_acc=0.
- Consecutive accumulates to the same address on back-to-back cycles must both apply (no lost update).
- Clear engine, states IDLE and CLEAR:
  - IDLE -> CLEAR on clr_start=1. The counter loads 0 and clr_busy rises after that edge.
  - In CLEAR, each cycle C[idx/N][idx%N] <= 0 (row-major) and idx increments.
  - After idx = M*N-1 is cleared: go to IDLE, clr_busy falls and clr_done=1 for one cycle. clr_busy is high for exactly M*N cycles.
  - clr_start while in CLEAR is ignored; no restart.
  - c_we=1 while clr_busy=1: the write/accumulate is dropped and c_wr_drop pulses on the following cycle.
  - c_we and clr_start on the same edge while IDLE: the write applies, then the clear zeroes it.
  - C reads during CLEAR are legal and return the current contents, which may be partially cleared.
  - A and B are unaffected by the clear engine.

Test Plan (M=K=N=4, DW_IN=8, DW_OUT=18):
- Reset, then read A[2][3], B[1][1], C[3][3] -> each rdata=0, rvalid=1 one cycle after re; with re=0 -> rvalid=0, rdata=0.
- Write A[1][2]=0xA5, and on the same edge read A[1][2] -> rdata=0x00. Read again next cycle -> 0xA5.
- C[0][1] overwrite 100, then accumulate +50 and +0x3FFFF on back-to-back cycles -> read returns 149 (wrap modulo 2^18).
- Fill C with nonzero values, pulse clr_start -> clr_busy high exactly 16 cycles, clr_done one pulse, all 16 C entries 0. A/B contents are unchanged.
- During clear, c_we=1 to C[3][3]=7 -> c_wr_drop pulse, C[3][3]=0 after done. Second clr_start mid-clear -> busy length still 16.
- Assert resetn=0 at cycle 5 of a clear -> clr_busy=0, no clr_done, all arrays 0. A new clr_start afterwards runs the full 16 cycles.

Source files
------------

// File: rtl/mac_mem_bank.sv
// Operand/result store for the MAC engine: A (MxK), B (KxN), C (MxN), each with one write and one read port.
// Reads are registered (1 cycle, read-first); C writes arriving while the clear engine runs are dropped.
module mac_mem_bank #(
  parameter int M      = 4,
  parameter int K      = 4,
  parameter int N      = 4,
  parameter int DW_IN  = 32,
  parameter int DW_OUT = 2*DW_IN+$clog2(K)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  a_we,
  input  logic [$clog2(M)-1:0]  a_wrow,
  input  logic [$clog2(K)-1:0]  a_wcol,
  input  logic [DW_IN-1:0]      a_wdata,
  input  logic                  a_re,
  input  logic [$clog2(M)-1:0]  a_rrow,
  input  logic [$clog2(K)-1:0]  a_rcol,
  output logic [DW_IN-1:0]      a_rdata,
  output logic                  a_rvalid,
  input  logic                  b_we,
  input  logic [$clog2(K)-1:0]  b_wrow,
  input  logic [$clog2(N)-1:0]  b_wcol,
  input  logic [DW_IN-1:0]      b_wdata,
  input  logic                  b_re,
  input  logic [$clog2(K)-1:0]  b_rrow,
  input  logic [$clog2(N)-1:0]  b_rcol,
  output logic [DW_IN-1:0]      b_rdata,
  output logic                  b_rvalid,
  input  logic                  c_we,
  input  logic                  c_acc,
  input  logic [$clog2(M)-1:0]  c_wrow,
  input  logic [$clog2(N)-1:0]  c_wcol,
  input  logic [DW_OUT-1:0]     c_wdata,
  input  logic                  c_re,
  input  logic [$clog2(M)-1:0]  c_rrow,
  input  logic [$clog2(N)-1:0]  c_rcol,
  output logic [DW_OUT-1:0]     c_rdata,
  output logic                  c_rvalid,
  input  logic                  clr_start,
  output logic                  clr_busy,
  output logic                  clr_done,
  output logic                  c_wr_drop
);
  localparam int MW = $clog2(M);
  localparam int NW = $clog2(N);
  localparam logic [MW-1:0] ROW_LAST = MW'(M-1);
  localparam logic [NW-1:0] COL_LAST = NW'(N-1);

  typedef enum logic {IDLE, CLEAR} state_t;

  logic [DW_IN-1:0]  a_mem [M][K];
  logic [DW_IN-1:0]  b_mem [K][N];
  logic [DW_OUT-1:0] c_mem [M][N];

  state_t        state, state_nxt;
  logic [MW-1:0] clr_row;
  logic [NW-1:0] clr_col;
  logic          clr_last;

  logic a_wr_ok, a_rd_ok, b_wr_ok, b_rd_ok, c_wr_ok, c_rd_ok;

  // Out-of-range indices only exist for non-power-of-2 dimensions.
  assign a_wr_ok = a_we && (int'(a_wrow) < M) && (int'(a_wcol) < K);
  assign a_rd_ok = (int'(a_rrow) < M) && (int'(a_rcol) < K);
  assign b_wr_ok = b_we && (int'(b_wrow) < K) && (int'(b_wcol) < N);
  assign b_rd_ok = (int'(b_rrow) < K) && (int'(b_rcol) < N);
  assign c_wr_ok = c_we && !clr_busy && (int'(c_wrow) < M) && (int'(c_wcol) < N);
  assign c_rd_ok = (int'(c_rrow) < M) && (int'(c_rcol) < N);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clr_start) state_nxt = CLEAR;
      CLEAR:   if (clr_last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    clr_busy = (state == CLEAR);
    clr_last = clr_busy && (clr_row == ROW_LAST) && (clr_col == COL_LAST);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      clr_row   <= '0;
      clr_col   <= '0;
      clr_done  <= 1'b0;
      c_wr_drop <= 1'b0;
    end else begin
      clr_done  <= clr_last;
      c_wr_drop <= c_we && clr_busy;
      if (state == IDLE && clr_start) begin
        clr_row <= '0;
        clr_col <= '0;
      end else if (clr_busy) begin
        if (clr_col == COL_LAST) begin
          clr_col <= '0;
          clr_row <= clr_row + 1'b1;
        end else begin
          clr_col <= clr_col + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < M; i++)
        for (int j = 0; j < K; j++)
          a_mem[i][j] <= '0;
      a_rdata  <= '0;
      a_rvalid <= 1'b0;
    end else begin
      if (a_wr_ok) a_mem[a_wrow][a_wcol] <= a_wdata;
      a_rvalid <= a_re;
      a_rdata  <= (a_re && a_rd_ok) ? a_mem[a_rrow][a_rcol] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < K; i++)
        for (int j = 0; j < N; j++)
          b_mem[i][j] <= '0;
      b_rdata  <= '0;
      b_rvalid <= 1'b0;
    end else begin
      if (b_wr_ok) b_mem[b_wrow][b_wcol] <= b_wdata;
      b_rvalid <= b_re;
      b_rdata  <= (b_re && b_rd_ok) ? b_mem[b_rrow][b_rcol] : '0;
    end
  end

  // The clear engine owns the C write port while busy; accumulation wraps modulo 2^DW_OUT.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < M; i++)
        for (int j = 0; j < N; j++)
          c_mem[i][j] <= '0;
      c_rdata  <= '0;
      c_rvalid <= 1'b0;
    end else begin
      if (clr_busy) begin
        c_mem[clr_row][clr_col] <= '0;
      end else if (c_wr_ok) begin
        c_mem[c_wrow][c_wcol] <= c_acc ? (c_mem[c_wrow][c_wcol] + c_wdata) : c_wdata;
      end
      c_rvalid <= c_re;
      c_rdata  <= (c_re && c_rd_ok) ? c_mem[c_rrow][c_rcol] : '0;
    end
  end

endmodule

// File: tb/tb_mac_mem_bank.sv
// Directed bench for mac_mem_bank (M=K=N=4, DW_IN=8, DW_OUT=18); read expectations go through a scoreboard queue
// filled from shadow arrays when each read is issued and drained after the following clock edge.
module tb_mac_mem_bank;
  logic        clk = 1'b0;
  logic        resetn;
  logic        a_we, a_re, b_we, b_re, c_we, c_acc, c_re, clr_start;
  logic [1:0]  a_wrow, a_wcol, a_rrow, a_rcol;
  logic [1:0]  b_wrow, b_wcol, b_rrow, b_rcol;
  logic [1:0]  c_wrow, c_wcol, c_rrow, c_rcol;
  logic [7:0]  a_wdata, a_rdata, b_wdata, b_rdata;
  logic [17:0] c_wdata, c_rdata;
  logic        a_rvalid, b_rvalid, c_rvalid, clr_busy, clr_done, c_wr_drop;

  typedef struct {
    string       tag;
    int          port;
    logic [17:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  sa [4][4];
  logic [7:0]  sb [4][4];
  logic [17:0] sc [4][4];
  int          tests = 0;
  int          fails = 0;
  int          bc, dc;

  mac_mem_bank #(.M(4), .K(4), .N(4), .DW_IN(8), .DW_OUT(18)) dut (
    .clk(clk), .resetn(resetn),
    .a_we(a_we), .a_wrow(a_wrow), .a_wcol(a_wcol), .a_wdata(a_wdata),
    .a_re(a_re), .a_rrow(a_rrow), .a_rcol(a_rcol), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
    .b_we(b_we), .b_wrow(b_wrow), .b_wcol(b_wcol), .b_wdata(b_wdata),
    .b_re(b_re), .b_rrow(b_rrow), .b_rcol(b_rcol), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
    .c_we(c_we), .c_acc(c_acc), .c_wrow(c_wrow), .c_wcol(c_wcol), .c_wdata(c_wdata),
    .c_re(c_re), .c_rrow(c_rrow), .c_rcol(c_rcol), .c_rdata(c_rdata), .c_rvalid(c_rvalid),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done), .c_wr_drop(c_wr_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    a_we = 0; a_re = 0; b_we = 0; b_re = 0; c_we = 0; c_acc = 0; c_re = 0; clr_start = 0;
  endtask

  // Advance one edge, sample 1 time unit later, drain the scoreboard, release strobes.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e.port)
        0: begin chk({e.tag, "_vld"}, 32'(a_rvalid), 1); chk(e.tag, 32'(a_rdata), 32'(e.data)); end
        1: begin chk({e.tag, "_vld"}, 32'(b_rvalid), 1); chk(e.tag, 32'(b_rdata), 32'(e.data)); end
        default: begin chk({e.tag, "_vld"}, 32'(c_rvalid), 1); chk(e.tag, 32'(c_rdata), 32'(e.data)); end
      endcase
    end
    idle_inputs();
  endtask

  task automatic rd(input int port, input int r, input int c, input string tag);
    exp_t e;
    e.tag = tag; e.port = port;
    case (port)
      0: begin a_re = 1; a_rrow = 2'(r); a_rcol = 2'(c); e.data = 18'(sa[r][c]); end
      1: begin b_re = 1; b_rrow = 2'(r); b_rcol = 2'(c); e.data = 18'(sb[r][c]); end
      default: begin c_re = 1; c_rrow = 2'(r); c_rcol = 2'(c); e.data = sc[r][c]; end
    endcase
    exp_q.push_back(e);
  endtask

  task automatic wr_a(input int r, input int c, input logic [7:0] d);
    a_we = 1; a_wrow = 2'(r); a_wcol = 2'(c); a_wdata = d; sa[r][c] = d;
  endtask

  task automatic wr_b(input int r, input int c, input logic [7:0] d);
    b_we = 1; b_wrow = 2'(r); b_wcol = 2'(c); b_wdata = d; sb[r][c] = d;
  endtask

  task automatic wr_c(input int r, input int c, input logic [17:0] d, input bit acc, input bit applies);
    c_we = 1; c_acc = acc; c_wrow = 2'(r); c_wcol = 2'(c); c_wdata = d;
    if (applies) sc[r][c] = acc ? 18'(sc[r][c] + d) : d;
  endtask

  task automatic zero_shadow(input bit ab);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        sc[i][j] = '0;
        if (ab) begin sa[i][j] = '0; sb[i][j] = '0; end
      end
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < 16; i++) begin
      rd(0, i / 4, i % 4, {tag, "_a"});
      rd(1, i / 4, i % 4, {tag, "_b"});
      rd(2, i / 4, i % 4, {tag, "_c"});
      step();
    end
  endtask

  // Start a clear and count busy/done cycles; with inject, also hit it with a C write and a second start.
  task automatic run_clear(input bit inject, output int busy_cnt, output int done_cnt);
    busy_cnt = 0; done_cnt = 0;
    clr_start = 1;
    if (inject) wr_c(2, 2, 18'd9, 0, 1);
    step();
    chk("busy_rise", 32'(clr_busy), 1);
    for (int i = 0; i < 40; i++) begin
      if (clr_busy) busy_cnt++;
      if (clr_done) done_cnt++;
      if (inject && i == 3) wr_c(3, 3, 18'd7, 0, 0);
      if (inject && i == 6) clr_start = 1;
      step();
      if (inject && i == 3) chk("wr_drop_pulse", 32'(c_wr_drop), 1);
      if (inject && i == 4) chk("wr_drop_single", 32'(c_wr_drop), 0);
    end
  endtask

  initial begin
    idle_inputs();
    a_wrow = 0; a_wcol = 0; a_rrow = 0; a_rcol = 0; a_wdata = 0;
    b_wrow = 0; b_wcol = 0; b_rrow = 0; b_rcol = 0; b_wdata = 0;
    c_wrow = 0; c_wcol = 0; c_rrow = 0; c_rcol = 0; c_wdata = 0;
    zero_shadow(1);

    resetn = 0;
    step(); step();
    resetn = 1;
    chk("rst_a_rvalid", 32'(a_rvalid), 0);
    chk("rst_c_rdata", 32'(c_rdata), 0);
    chk("rst_busy", 32'(clr_busy), 0);
    chk("rst_done", 32'(clr_done), 0);
    chk("rst_drop", 32'(c_wr_drop), 0);

    rd(0, 2, 3, "rst_a23"); rd(1, 1, 1, "rst_b11"); rd(2, 3, 3, "rst_c33");
    step();
    step();
    chk("idle_a_rvalid", 32'(a_rvalid), 0);
    chk("idle_b_rvalid", 32'(b_rvalid), 0);
    chk("idle_c_rvalid", 32'(c_rvalid), 0);
    chk("idle_a_rdata", 32'(a_rdata), 0);

    // Read-first on A: same-edge read sees the old value, next read sees the new one.
    rd(0, 1, 2, "rdw_old");
    wr_a(1, 2, 8'hA5);
    step();
    rd(0, 1, 2, "rdw_new");
    step();

    // Overwrite then back-to-back accumulates, the last one wrapping modulo 2^18.
    wr_c(0, 1, 18'd100, 0, 1); step();
    wr_c(0, 1, 18'd50, 1, 1); step();
    wr_c(0, 1, 18'h3FFFF, 1, 1); step();
    rd(2, 0, 1, "acc_wrap");
    step();
    chk("acc_model", 32'(sc[0][1]), 149);

    for (int i = 0; i < 16; i++) begin
      wr_a(i / 4, i % 4, 8'(i * 3 + 1));
      wr_b(i / 4, i % 4, 8'(8'h80 + i));
      wr_c(i / 4, i % 4, 18'(i * 1000 + 1), 0, 1);
      step();
    end
    read_all("fill");

    run_clear(1, bc, dc);
    chk("clr_busy_len", 32'(bc), 16);
    chk("clr_done_cnt", 32'(dc), 1);
    zero_shadow(0);
    read_all("post_clr");

    for (int i = 0; i < 16; i++) begin
      wr_c(i / 4, i % 4, 18'(i + 5), 0, 1);
      step();
    end
    clr_start = 1;
    step();
    for (int i = 0; i < 4; i++) step();
    chk("mid_busy", 32'(clr_busy), 1);
    resetn = 0;
    step();
    resetn = 1;
    chk("abort_busy", 32'(clr_busy), 0);
    dc = 0;
    for (int i = 0; i < 20; i++) begin
      if (clr_done) dc++;
      step();
    end
    chk("abort_no_done", 32'(dc), 0);
    zero_shadow(1);
    read_all("post_rst");

    run_clear(0, bc, dc);
    chk("reclr_busy_len", 32'(bc), 16);
    chk("reclr_done_cnt", 32'(dc), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end
endmodule
